rv_fetch_unit: RTL and testbench



---
 rtl/rv_fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_rv_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_unit.sv
// ---------------------------------------------------------------------------
// rv_fetch_unit
//   Instruction-fetch front end for the RV32 core. A PC sequencer issues
//   word-aligned requests to instruction memory under a credit rule. The rule
//   allows no more requests in flight than there is free prefetch FIFO space.
//   Returned words are tagged with their PC, queued, and presented to decode.
//   A redirect flushes the FIFO and discards responses that are still in flight.
//
//   State table
//     state   | meaning
//     --------+-------------------------------------------------------------
//     ST_RUN  | normal fetching; requests issue while credit is available
//     ST_HALT | last redirect target was misaligned; no requests issue
//
// Ports
//   clk             in   clock, rising edge
//   n_rst           in   asynchronous active-low reset
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts the request this cycle
//   imem_req_addr   out  word-aligned fetch address
//   imem_rsp_valid  in   response valid (in request order, >=1 cycle later)
//   imem_rsp_data   in   instruction word
//   instr_valid     out  FIFO head valid
//   instr_ready     in   decode consumes the head
//   instr           out  head instruction
//   instr_pc        out  PC of the head instruction
//   redirect_valid  in   single-cycle redirect request
//   redirect_pc     in   redirect target
//   err_misaligned  out  last redirect target was not word aligned
// ---------------------------------------------------------------------------
module rv_fetch_unit #(
  parameter int               XLEN       = 32,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
  input  logic             clk,
  input  logic             n_rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [XLEN-1:0]  imem_rsp_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [XLEN-1:0]  instr,
  output logic [XLEN-1:0]  instr_pc,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             err_misaligned
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   run;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  rsp_pc;
  logic [CNT_W-1:0] outstanding_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic [XLEN-1:0]  fifo_instr [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_pc    [FIFO_DEPTH];

  logic [XLEN-1:0]  redirect_aligned;
  logic [CNT_W:0]   credit_used;
  logic             req_fire;
  logic             push;
  logic             pop;

  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = (redirect_pc[1:0] != 2'b00) ? ST_HALT : ST_RUN;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run            = (state == ST_RUN);
    err_misaligned = (state == ST_HALT);
  end

  // Every word in flight already owns a FIFO slot, so a push can never hit a
  // full FIFO. The n_rst term keeps the request low while reset is held.
  assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_cnt};
  assign imem_req_valid = n_rst & run & ~redirect_valid &
                          (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response that arrives in the redirect cycle is stale by definition.
  assign push = imem_rsp_valid & ~redirect_valid & (drop_cnt == '0);
  assign pop  = instr_ready & (fifo_count != '0) & ~redirect_valid;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fetch_pc        <= RESET_PC;
      rsp_pc          <= RESET_PC;
      outstanding_cnt <= '0;
      drop_cnt        <= '0;
      fifo_count      <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end

      // The outstanding count follows the memory itself, so it keeps counting
      // through redirects and includes responses that will be dropped.
      case ({req_fire, imem_rsp_valid})
        2'b10:   outstanding_cnt <= outstanding_cnt + CNT_W'(1);
        2'b01:   outstanding_cnt <= outstanding_cnt - CNT_W'(1);
        default: outstanding_cnt <= outstanding_cnt;
      endcase

      if (redirect_valid) begin
        drop_cnt <= outstanding_cnt - CNT_W'(imem_rsp_valid);
      end else if (imem_rsp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end

      if (redirect_valid) begin
        rsp_pc <= redirect_aligned;
      end else if (push) begin
        rsp_pc <= rsp_pc + XLEN'(4);
      end

      if (redirect_valid) begin
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CNT_W'(1);
          2'b01:   fifo_count <= fifo_count - CNT_W'(1);
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  // Storage carries no reset; validity is tracked by fifo_count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]    <= rsp_pc;
    end
  end

  assign instr_valid = (fifo_count != '0);
  assign instr       = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];

endmodule

// File: tb/tb_rv_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_rv_fetch_unit
//   Randomised bench for rv_fetch_unit. The bench contains a latency-
//   programmable, in-order memory model. A reference model tracks the
//   architectural stream that decode should see. Each entry that memory
//   hands back and that is not stale pushes an expected {pc, word} onto a
//   scoreboard queue. A separate monitor pops that queue whenever decode
//   consumes an instruction.
// ---------------------------------------------------------------------------
module tb_rv_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk;
  logic        n_rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        err_misaligned;

  rv_fetch_unit #(
    .XLEN       (32),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .err_misaligned (err_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  req_t        pend[$];
  exp_t        exp_q[$];
  int          occ;
  bit          halted;
  logic [31:0] mfetch;
  int          cyc;
  int          n_tests;
  int          n_fail;
  int          pop_cnt;
  int          req_cnt;
  int          lat_min;
  int          lat_max;
  int          ready_pct;
  int          iready_pct;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: credit rule, architectural fetch pointer, FIFO occupancy
  // and the stale marking of responses that belong to a flushed stream.
  bit   exp_rv;
  bit   do_pop;
  req_t r;
  always @(negedge clk) begin
    if (!n_rst) begin
      check1("req_valid_in_reset", imem_req_valid, 1'b0);
    end else begin
      exp_rv = !halted && !redirect_valid && ((occ + pend.size()) < DEPTH);
      check1("req_valid", imem_req_valid, exp_rv);
      if (imem_req_valid) check32("req_addr", imem_req_addr, mfetch);
      check1("instr_valid", instr_valid, occ != 0);
      check1("err_misaligned", err_misaligned, halted);

      do_pop = (occ != 0) && instr_ready && !redirect_valid;
      if (imem_rsp_valid && pend.size() > 0) begin
        r = pend.pop_front();
        if (!redirect_valid && !r.stale) begin
          exp_q.push_back('{r.addr, mem_word(r.addr)});
          occ++;
        end
      end
      if (redirect_valid) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        exp_q.delete();
        occ    = 0;
        mfetch = {redirect_pc[31:2], 2'b00};
        halted = (redirect_pc[1:0] != 2'b00);
      end else begin
        if (do_pop) begin
          occ--;
          pop_cnt++;
        end
        if (imem_req_valid && imem_req_ready) begin
          pend.push_back('{mfetch, cyc + int'($urandom_range(lat_min, lat_max)), 1'b0});
          mfetch += 32'd4;
          req_cnt++;
        end
      end
    end
  end

  // Monitor: compares what decode consumes against the scoreboard.
  exp_t e;
  always @(negedge clk) begin
    if (n_rst && instr_valid && instr_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got instr_pc %h expected no valid entry (cycle %0d)",
                 instr_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        check32("instr_pc", instr_pc, e.pc);
        check32("instr", instr, e.data);
      end
    end
  end

  // One cycle of stimulus: drive the memory response and random readies
  // just after the rising edge. A caller may then add a redirect.
  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    imem_req_ready = ($urandom_range(1, 100) <= ready_pct);
    instr_ready    = ($urandom_range(1, 100) <= iready_pct);
    if (n_rst && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    advance();
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
  endtask

  // Reset also clears the memory model: in-flight responses are dropped.
  task automatic do_reset();
    advance();
    n_rst          = 1'b0;
    imem_rsp_valid = 1'b0;
    pend.delete();
    exp_q.delete();
    occ    = 0;
    halted = 1'b0;
    mfetch = RST_PC;
    repeat (3) advance();
    n_rst = 1'b1;
  endtask

  int  snap;
  bit  found;
  logic [31:0] tgt;

  initial begin
    n_rst          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    n_tests = 0; n_fail = 0; cyc = 0; pop_cnt = 0; req_cnt = 0;
    occ = 0; halted = 1'b0; mfetch = RST_PC;
    lat_min = 1; lat_max = 1; ready_pct = 100; iready_pct = 100;

    // Reset, sequential fetch across the 32-bit wrap, sustained throughput.
    do_reset();
    repeat (10) advance();
    snap = pop_cnt;
    repeat (20) advance();
    check32("throughput_pops", pop_cnt - snap, 20);

    // Backpressure: exactly DEPTH requests, then resume without loss.
    iready_pct = 0;
    do_redirect(32'h0);
    snap = req_cnt;
    repeat (12) advance();
    check32("bp_req_count", req_cnt - snap, DEPTH);
    check32("bp_head_pc", instr_pc, 32'h0);
    iready_pct = 100;
    repeat (20) advance();

    // Redirect with two requests in flight on 3-cycle memory.
    lat_min = 3; lat_max = 3;
    do_redirect(32'h80);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      advance();
      if (pend.size() == 2) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        found = 1'b1;
      end
    end
    check1("redirect_2_outstanding_reached", found, 1'b1);
    repeat (20) advance();

    // Redirect coinciding with a response and a pop.
    lat_min = 2; lat_max = 2; iready_pct = 50;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      advance();
      if (imem_rsp_valid && occ > 0 && pend.size() >= 2) begin
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        found = 1'b1;
      end
    end
    check1("simul_redirect_reached", found, 1'b1);
    iready_pct = 100;
    repeat (20) advance();

    // Misaligned redirect halts fetch; an aligned redirect recovers.
    do_redirect(32'h102);
    repeat (8) advance();
    check1("halt_err", err_misaligned, 1'b1);
    do_redirect(32'h200);
    repeat (10) advance();

    // Random traffic with redirects, misaligned targets and a mid-run reset.
    lat_min = 1; lat_max = 4; ready_pct = 70; iready_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
      end else begin
        advance();
        if (halted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 29) == 0)) begin
          tgt = $urandom & 32'hFFFF_FFFC;
          if (!halted && $urandom_range(0, 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
          redirect_valid = 1'b1;
          redirect_pc    = tgt;
        end
      end
    end
    ready_pct = 100; iready_pct = 100;
    repeat (20) advance();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
